matrix_loader: RTL and testbench
================================

// Module: matrix_loader
// PURPOSE
//  Upstream feeder for the systemizer. Accepts a byte stream of GF(M) symbols and rejection-samples it
//  (symbols >= M are discarded). Packs two elements per word and writes the L x K matrix row-major into the
//  shared matrix RAM. Then kicks the systemizer, waits for its done, and latches its success/fail verdict.
// PARAMETERS
//  L   8   matrix rows
//  K   10  matrix columns; L*K must be even
//  M   3   field size; element width EW = `CLOG2(M)
//  (derived) WORDS = L*K/2; AW = `CLOG2(L*K/2); DW = 2*EW. Defaults give WORDS=40, AW=6, EW=2, DW=4
// PORTS
//  clk          in   1    clock
//  rst          in   1    synchronous reset, active-high
//  start        in   1    begin a load; honoured only in IDLE or DONE
//  in_valid     in   1    symbol byte valid
//  in_ready     out  1    high only in LOAD
//  in_data      in   8    symbol; only in_data[EW-1:0] used, upper bits ignored
//  wr_en        out  1    RAM write strobe (registered)
//  wr_addr      out  AW   RAM word address (registered)
//  data_in      out  DW   packed word {odd elem, even elem} (registered)
//  sys_start    out  1    one-cycle start pulse to systemizer
//  sys_done     in   1    systemizer finished
//  sys_success  in   1    systemizer verdict, sampled with sys_done
//  sys_fail     in   1    systemizer verdict, sampled with sys_done
//  busy         out  1    high in LOAD, KICK, WAIT
//  done         out  1    high in DONE until next start or rst
//  success      out  1    latched verdict, valid while done
//  fail         out  1    latched verdict, valid while done
//  reject_cnt   out  8    symbols discarded this load; saturates at 255
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0, including in_ready, wr_en, wr_addr, data_in, sys_start, reject_cnt.
//  FSM:
//   IDLE -start-> LOAD. Entry clears elem/addr counters, reject_cnt and the success/fail latches.
//   LOAD -last word written-> KICK.
//   KICK (1 cycle, sys_start=1) -> WAIT.
//   WAIT -sys_done-> DONE.
//   DONE -start-> LOAD. start in any other state is ignored.
//  Symbol accept: when in_valid && in_ready, let s = in_data[EW-1:0].
//   s >= M: dropped; reject_cnt++ (saturating); no element counted.
//   s < M: if the element is even, hold s in the low-half register.
//          if the element is odd, next cycle: wr_en=1, wr_addr=word index, data_in={s, low}.
//  Write latency is 1 cycle after the odd handshake. wr_en is high for exactly one cycle per word.
//  Addresses run 0..WORDS-1 with no wrap.
//  On the WORDS-1 write, in_ready drops in that same cycle. Symbols beyond L*K are never taken.
//  sys_start pulses in the cycle after the final wr_en.
//  Gaps in in_valid simply stall the load; there is no timeout.
//  sys_done is sampled in WAIT only; it is ignored in KICK.
//  If sys_success and sys_fail are both high, then fail=1 and success=0.
//  rst mid-operation: back to IDLE next edge; any partial word is discarded; no write and no sys_start.
// STRUCTURE
//  Shared include header beside clog2.v holds the derived constants EW, AW, DW, WORDS and the state
//  encodings. These are shared with the systemizer so packing and addressing match.
//  No sub-module: FSM, counters and packer stay in a single flat module.
// TESTING (defaults L=8 K=10 M=3)
//  1. Hold rst 2 cycles -> every output 0, in_ready=0. start while rst=1 -> ignored.
//  2. start, stream 0,1,2,0,1,2,... (80 symbols, no gaps) -> 40 writes at addr 0..39 with
//     data 4'b0100, 4'b0010, 4'b1001, ... Then one sys_start the cycle after addr 39.
//  3. Insert value 3 (and 0xFF) after every 3rd valid symbol -> no write for those, reject_cnt=26,
//     same 40-word image as test 2.
//  4. Random in_valid gaps and symbols offered after completion -> identical RAM image, in_ready=0 after word 39.
//  5. sys_done with success=1 -> done=1, success=1, busy=0. Rerun with fail=1 -> fail=1.
//     Both high -> fail=1, success=0. A second start in DONE reloads from addr 0.
//  6. rst asserted after the word-17 write -> next cycle wr_en=0, state IDLE, no sys_start.
//     A fresh start rewrites from addr 0.

Source files
------------

// File: rtl/matrix_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_loader_pkg
// Description : Shared sizing helper and state encoding for the matrix loader
//               and the systemizer, so packing and addressing agree.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_loader_pkg;

    localparam int DEF_L = 8;
    localparam int DEF_K = 10;
    localparam int DEF_M = 3;

    localparam int SYM_W = 8;
    localparam int REJ_W = 8;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_KICK = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/matrix_loader.sv
`default_nettype none
// ============================================================================
// Module      : matrix_loader
// Description : Rejection-samples a GF(M) byte stream, packs two elements per
//               word into the matrix RAM, then kicks the systemizer and
//               latches its verdict.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_loader
    import matrix_loader_pkg::*;
#(
    parameter  int L     = DEF_L,
    parameter  int K     = DEF_K,
    parameter  int M     = DEF_M,
    localparam int EW    = clog2(M),
    localparam int WORDS = L * K / 2,
    localparam int AW    = clog2(L * K / 2),
    localparam int DW    = 2 * EW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] in_data,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [DW-1:0]    data_in,
    output logic             sys_start,
    input  logic             sys_done,
    input  logic             sys_success,
    input  logic             sys_fail,
    output logic             busy,
    output logic             done,
    output logic             success,
    output logic             fail,
    output logic [REJ_W-1:0] reject_cnt
);

    localparam logic [EW:0]    c_m_ext     = (EW + 1)'(M);
    localparam logic [AW-1:0]  c_last_addr = AW'(WORDS - 1);
    localparam logic [REJ_W-1:0] c_rej_max = '1;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_wr_en;
    logic [AW-1:0]      r_wr_addr;
    logic [DW-1:0]      r_data_in;
    logic               r_sys_start;
    logic               r_busy;
    logic               r_done;
    logic               r_success;
    logic               r_fail;
    logic [REJ_W-1:0]   r_reject_cnt;

    logic               r_odd;
    logic [AW-1:0]      r_word_idx;
    logic [EW-1:0]      r_low;

    logic [EW-1:0]      w_sym;
    logic               w_take;
    logic               w_accept;
    logic               w_reject;
    logic               w_last_word;
    logic               w_unused_bits;

    assign w_sym         = in_data[EW-1:0];
    assign w_take        = in_valid && r_in_ready;
    assign w_accept      = w_take && ({1'b0, w_sym} < c_m_ext);
    assign w_reject      = w_take && !({1'b0, w_sym} < c_m_ext);
    assign w_last_word   = (r_word_idx == c_last_addr);
    assign w_unused_bits = ^in_data[SYM_W-1:EW];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_in_ready   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_data_in    <= '0;
            r_sys_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_success    <= 1'b0;
            r_fail       <= 1'b0;
            r_reject_cnt <= '0;
            r_odd        <= 1'b0;
            r_word_idx   <= '0;
            r_low        <= '0;
        end else begin
            r_wr_en     <= 1'b0;
            r_sys_start <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_LOAD;
                        r_in_ready   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_success    <= 1'b0;
                        r_fail       <= 1'b0;
                        r_reject_cnt <= '0;
                        r_odd        <= 1'b0;
                        r_word_idx   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_reject && (r_reject_cnt != c_rej_max)) begin
                        r_reject_cnt <= r_reject_cnt + 1'b1;
                    end
                    if (w_accept) begin
                        if (!r_odd) begin
                            r_low <= w_sym;
                            r_odd <= 1'b1;
                        end else begin
                            r_wr_en    <= 1'b1;
                            r_wr_addr  <= r_word_idx;
                            r_data_in  <= {w_sym, r_low};
                            r_odd      <= 1'b0;
                            r_word_idx <= r_word_idx + 1'b1;
                            // Stop taking symbols as the final word goes out.
                            if (w_last_word) begin
                                r_in_ready <= 1'b0;
                            end
                        end
                    end
                    if (r_wr_en && (r_wr_addr == c_last_addr)) begin
                        r_state     <= ST_KICK;
                        r_sys_start <= 1'b1;
                    end
                end
                ST_KICK: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (sys_done) begin
                        r_state   <= ST_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        // A contradictory verdict is treated as a failure.
                        r_success <= sys_success && !sys_fail;
                        r_fail    <= sys_fail;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign data_in    = r_data_in;
    assign sys_start  = r_sys_start;
    assign busy       = r_busy;
    assign done       = r_done;
    assign success    = r_success;
    assign fail       = r_fail;
    assign reject_cnt = r_reject_cnt;

endmodule
`default_nettype wire

// File: tb/tb_matrix_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_loader
// Description : Self-checking bench for matrix_loader at default sizing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [3:0] data_in;
    logic       sys_start;
    logic       sys_done = 1'b0;
    logic       sys_success = 1'b0;
    logic       sys_fail = 1'b0;
    logic       busy;
    logic       done;
    logic       success;
    logic       fail;
    logic [7:0] reject_cnt;

    matrix_loader dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in),
        .sys_start(sys_start), .sys_done(sys_done),
        .sys_success(sys_success), .sys_fail(sys_fail),
        .busy(busy), .done(done), .success(success), .fail(fail),
        .reject_cnt(reject_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    typedef struct packed {
        logic [5:0] addr;
        logic [3:0] data;
    } wr_t;

    wr_t        sb[$];
    bit         m_odd;
    logic [1:0] m_low;
    int         m_word;
    int         m_rej;
    bit         exp_kick = 1'b0;

    function automatic void model_take(input logic [7:0] b);
        logic [1:0] s;
        wr_t e;
        s = b[1:0];
        if (s >= 2'd3) begin
            if (m_rej < 255) m_rej++;
        end else if (!m_odd) begin
            m_low = s;
            m_odd = 1'b1;
        end else begin
            e.addr = 6'(m_word);
            e.data = {s, m_low};
            sb.push_back(e);
            m_word++;
            m_odd = 1'b0;
        end
    endfunction

    // Write and kick monitor, sampled mid-cycle.
    always @(negedge clk) begin
        bit  kick_now;
        wr_t e;
        kick_now = exp_kick;
        exp_kick = 1'b0;
        if (kick_now || sys_start) chk("sys_start", int'(sys_start), int'(kick_now));
        if (wr_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", int'(wr_addr), int'(e.addr));
                chk("wr_data", int'(data_in), int'(e.data));
                chk("in_ready_at_write", int'(in_ready), int'(e.addr != 6'd39));
                if (e.addr == 6'd39) exp_kick = 1'b1;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        bit taken;
        taken = 1'b0;
        for (int t = 0; t < 50 && !taken; t++) begin
            in_valid = 1'b1;
            in_data  = b;
            taken    = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (taken) model_take(b);
        else chk("send_timeout", 0, 1);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        m_odd  = 1'b0;
        m_word = 0;
        m_rej  = 0;
        chk("in_ready_after_start", int'(in_ready), 1);
        chk("busy_after_start", int'(busy), 1);
        chk("done_cleared", int'(done), 0);
    endtask

    task automatic stream(input int pattern);
        for (int i = 0; i < 80; i++) begin
            if (pattern == 2) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if (pattern == 2) send(8'(i % 3) | 8'hF4);
            else send(8'(i % 3));
            if (pattern == 1 && (i % 3) == 2) send(((i / 3) % 2) != 0 ? 8'hFF : 8'h03);
        end
    endtask

    // Finish a load: sys_done during KICK must be ignored, late symbols refused.
    task automatic finish_load(input bit s_ok, input bit s_fl, input bit e_s, input bit e_f, input int e_rej);
        bit seen;
        bit taken;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(posedge clk); #1;
            seen = sys_start;
        end
        chk("kick_seen", int'(seen), 1);
        sys_done = 1'b1;
        @(posedge clk); #1;
        sys_done = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            in_data  = 8'(j);
            taken    = in_ready;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("late_take", int'(taken), 0);
        end
        chk("done_ignored_in_kick", int'(done), 0);
        chk("busy_in_wait", int'(busy), 1);
        sys_done = 1'b1; sys_success = s_ok; sys_fail = s_fl;
        @(posedge clk); #1;
        sys_done = 1'b0; sys_success = 1'b0; sys_fail = 1'b0;
        chk("done", int'(done), 1);
        chk("busy_after_done", int'(busy), 0);
        chk("success", int'(success), int'(e_s));
        chk("fail", int'(fail), int'(e_f));
        chk("reject_cnt", int'(reject_cnt), e_rej);
        chk("words_written", m_word, 40);
        chk("pending_writes", sb.size(), 0);
    endtask

    typedef struct {
        int pattern;
        bit s_ok;
        bit s_fl;
        bit e_s;
        bit e_f;
        int e_rej;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{pattern: 0, s_ok: 1'b1, s_fl: 1'b0, e_s: 1'b1, e_f: 1'b0, e_rej: 0};
        vecs[1] = '{pattern: 1, s_ok: 1'b0, s_fl: 1'b1, e_s: 1'b0, e_f: 1'b1, e_rej: 26};
        vecs[2] = '{pattern: 2, s_ok: 1'b1, s_fl: 1'b1, e_s: 1'b0, e_f: 1'b1, e_rej: 0};
        vecs[3] = '{pattern: 0, s_ok: 1'b0, s_fl: 1'b0, e_s: 1'b0, e_f: 1'b0, e_rej: 0};

        // Reset with start held high.
        rst = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_data_in", int'(data_in), 0);
        chk("rst_sys_start", int'(sys_start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_success", int'(success), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_reject_cnt", int'(reject_cnt), 0);
        rst = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        chk("start_in_rst_ignored", int'(busy), 0);

        for (int v = 0; v < 4; v++) begin
            do_start();
            stream(vecs[v].pattern);
            finish_load(vecs[v].s_ok, vecs[v].s_fl, vecs[v].e_s, vecs[v].e_f, vecs[v].e_rej);
        end

        // Reset right as word 17 is written, then reload.
        do_start();
        for (int i = 0; i < 36; i++) send(8'(i % 3));
        chk("word17_write", int'(wr_en), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_wr_en", int'(wr_en), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_busy", int'(busy), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_idle", int'(busy), 0);
        sb.delete();
        do_start();
        stream(0);
        finish_load(1'b1, 1'b0, 1'b1, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1, expected 0");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
